// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - MMCM reset pulsing, lock wait with bounded retries, and game reset release
//
// Ports:
//   clk          board input clock; all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   i_locked     MMCM LOCKED (asynchronous, synchronised here by two flops)
//   i_restart    single-cycle request to restart the whole sequence
//   o_mmcm_rst   MMCM reset, active-high
//   o_game_rst_n game reset, active-low, released only while running
//   o_ready      high only while running
//   o_fault      high only after exhausting lock retries
//   o_retries    failed lock attempts, saturating at MAX_RETRIES

module clk_rst_sequencer #(
  parameter int RST_PULSE_CYCLES = 8,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int RELEASE_DELAY    = 256,
  parameter int MAX_RETRIES      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_locked,
  input  logic       i_restart,
  output logic       o_mmcm_rst,
  output logic       o_game_rst_n,
  output logic       o_ready,
  output logic       o_fault,
  output logic [3:0] o_retries
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_AB > RELEASE_DELAY) ? MAX_AB : RELEASE_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_END   = CW'(RST_PULSE_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RELEASE_END = CW'(RELEASE_DELAY - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PULSE     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [3:0]    retries_next;
  logic [3:0]    retries_inc;
  logic [1:0]    locked_ff;
  logic          locked_sync;

  assign locked_sync = locked_ff[1];
  assign retries_inc = (o_retries == RETRY_LIMIT) ? o_retries : o_retries + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_ff <= 2'b00;
    end else begin
      locked_ff <= {locked_ff[0], i_locked};
    end
  end

  // The counter counts pulse cycles already spent. After reset or restart the
  // output is already high before the first counted edge, so those start at 0.
  // Re-entry from a failed or lost lock loads 1 because the entry edge itself
  // is the first cycle of the new pulse.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    retries_next = o_retries;

    if (i_restart) begin
      state_next   = PULSE;
      cnt_next     = '0;
      retries_next = 4'd0;
    end else begin
      case (state)
        PULSE: begin
          if (cnt == PULSE_END) begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          // Lock is tested first so it wins over a coincident timeout.
          if (locked_sync) begin
            state_next = STABILIZE;
            cnt_next   = '0;
          end else if (cnt == TIMEOUT_END) begin
            retries_next = retries_inc;
            if (retries_inc == RETRY_LIMIT) begin
              state_next = FAULT;
              cnt_next   = '0;
            end else begin
              state_next = PULSE;
              cnt_next   = CNT_ONE;
            end
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        STABILIZE: begin
          if (!locked_sync) begin
            state_next = PULSE;
            cnt_next   = CNT_ONE;
          end else if (cnt == RELEASE_END) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end

        RUN: begin
          if (!locked_sync) begin
            state_next = PULSE;
            cnt_next   = CNT_ONE;
          end
        end

        FAULT: begin
          state_next = FAULT;
        end

        default: begin
          state_next = PULSE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PULSE;
      cnt          <= '0;
      o_retries    <= 4'd0;
      o_mmcm_rst   <= 1'b1;
      o_game_rst_n <= 1'b0;
      o_ready      <= 1'b0;
      o_fault      <= 1'b0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      o_retries    <= retries_next;
      o_mmcm_rst   <= (state_next == PULSE);
      o_game_rst_n <= (state_next == RUN);
      o_ready      <= (state_next == RUN);
      o_fault      <= (state_next == FAULT);
    end
  end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - self-checking bench for clk_rst_sequencer

module tb_clk_rst_sequencer;

  localparam int RP    = 4;
  localparam int LT    = 20;
  localparam int RD    = 8;
  localparam int MR    = 3;
  localparam int NEVER = 1000000;

  logic       clk;
  logic       rst_n;
  logic       i_locked;
  logic       i_restart;
  logic       o_mmcm_rst;
  logic       o_game_rst_n;
  logic       o_ready;
  logic       o_fault;
  logic [3:0] o_retries;
  logic [7:0] act;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;

  clk_rst_sequencer #(
    .RST_PULSE_CYCLES(RP),
    .LOCK_TIMEOUT    (LT),
    .RELEASE_DELAY   (RD),
    .MAX_RETRIES     (MR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_locked    (i_locked),
    .i_restart   (i_restart),
    .o_mmcm_rst  (o_mmcm_rst),
    .o_game_rst_n(o_game_rst_n),
    .o_ready     (o_ready),
    .o_fault     (o_fault),
    .o_retries   (o_retries)
  );

  assign act = {o_mmcm_rst, o_game_rst_n, o_ready, o_fault, o_retries};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] pk(input bit m, input bit g, input bit r, input bit f, input int ret);
    return {m, g, r, f, 4'(ret)};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got {mmcm,game,ready,fault,ret}=%b_%h expected %b_%h",
               name, ecount, got[7:4], got[3:0], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_locked  = 1'b0;
    i_restart = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    ecount = 0;
  endtask

  task automatic step();
    @(posedge clk);
    ecount++;
    #1;
  endtask

  // Drive edges up to target. Lock is sampled high on edges in [rise, fall)
  // except the gap [glo, ghi]; restart is sampled high on edge rs only.
  task automatic advance(input int target, input int rise, input int fall,
                         input int glo, input int ghi, input int rs);
    while (ecount < target) begin
      int e;
      e = ecount + 1;
      i_locked  = (e >= rise) && (e < fall) && !((e >= glo) && (e <= ghi));
      i_restart = (e == rs);
      step();
    end
    i_restart = 1'b0;
  endtask

  // Reference model: phase plus absolute deadline edge, lock history array.
  string m_ph;
  int    m_pend;
  int    m_ret;
  int    m_e;
  bit    m_hist [0:8191];

  task automatic model_reset();
    m_ph   = "pulse";
    m_pend = RP + 1;
    m_ret  = 0;
    m_e    = 0;
  endtask

  task automatic model_edge(input bit lk, input bit rs);
    bit ls;
    m_e++;
    m_hist[m_e] = lk;
    ls = (m_e > 2) ? m_hist[m_e - 2] : 1'b0;
    if (rs) begin
      m_ph   = "pulse";
      m_ret  = 0;
      m_pend = m_e + RP + 1;
    end else if (m_ph == "pulse") begin
      if (m_e == m_pend) begin
        m_ph   = "wait";
        m_pend = m_e + LT;
      end
    end else if (m_ph == "wait") begin
      if (ls) begin
        m_ph   = "stab";
        m_pend = m_e + RD;
      end else if (m_e == m_pend) begin
        m_ret++;
        if (m_ret == MR) m_ph = "fault";
        else begin
          m_ph   = "pulse";
          m_pend = m_e + RP;
        end
      end
    end else if (m_ph == "stab") begin
      if (!ls) begin
        m_ph   = "pulse";
        m_pend = m_e + RP;
      end else if (m_e == m_pend) begin
        m_ph = "run";
      end
    end else if (m_ph == "run") begin
      if (!ls) begin
        m_ph   = "pulse";
        m_pend = m_e + RP;
      end
    end
  endtask

  function automatic logic [7:0] model_exp();
    return pk(m_ph == "pulse", m_ph == "run", m_ph == "run", m_ph == "fault", m_ret);
  endfunction

  typedef struct {
    string      name;
    int         rise;
    int         at;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input int rise, input int at, input logic [7:0] exp);
    vec_t v;
    v.name = name;
    v.rise = rise;
    v.at   = at;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  bit lk;
  bit rs;
  int rate;
  int start_fail;

  initial begin
    add_vec("reset_values",      NEVER, 0,   pk(1, 0, 0, 0, 0));
    add_vec("nom_pulse_last",    10,    4,   pk(1, 0, 0, 0, 0));
    add_vec("nom_pulse_fall",    10,    5,   pk(0, 0, 0, 0, 0));
    add_vec("nom_before_run",    10,    19,  pk(0, 0, 0, 0, 0));
    add_vec("nom_run",           10,    20,  pk(0, 1, 1, 0, 0));
    add_vec("nom_run_hold",      10,    30,  pk(0, 1, 1, 0, 0));
    add_vec("to_before",         32,    24,  pk(0, 0, 0, 0, 0));
    add_vec("to_pulse",          32,    25,  pk(1, 0, 0, 0, 1));
    add_vec("to_pulse_last",     32,    28,  pk(1, 0, 0, 0, 1));
    add_vec("to_wait",           32,    29,  pk(0, 0, 0, 0, 1));
    add_vec("to_before_run",     32,    41,  pk(0, 0, 0, 0, 1));
    add_vec("to_run",            32,    42,  pk(0, 1, 1, 0, 1));
    add_vec("flt_retry1_hold",   NEVER, 48,  pk(0, 0, 0, 0, 1));
    add_vec("flt_retry2",        NEVER, 49,  pk(1, 0, 0, 0, 2));
    add_vec("flt_before",        NEVER, 72,  pk(0, 0, 0, 0, 2));
    add_vec("flt_enter",         NEVER, 73,  pk(0, 0, 0, 1, 3));
    add_vec("flt_stay",          NEVER, 120, pk(0, 0, 0, 1, 3));

    foreach (vecs[i]) begin
      do_reset();
      advance(vecs[i].at, vecs[i].rise, NEVER, NEVER, NEVER, NEVER);
      check(vecs[i].name, act, vecs[i].exp);
    end

    // Fault then restart: cleared on the restart edge, full pulse follows.
    do_reset();
    advance(80, NEVER, NEVER, NEVER, NEVER, NEVER);
    check("restart_pre", act, pk(0, 0, 0, 1, 3));
    advance(81, NEVER, NEVER, NEVER, NEVER, 81);
    check("restart_edge", act, pk(1, 0, 0, 0, 0));
    advance(85, NEVER, NEVER, NEVER, NEVER, NEVER);
    check("restart_pulse_last", act, pk(1, 0, 0, 0, 0));
    advance(86, NEVER, NEVER, NEVER, NEVER, NEVER);
    check("restart_pulse_end", act, pk(0, 0, 0, 0, 0));

    // Lock loss in RUN, then relock and resequence.
    do_reset();
    advance(41, 10, NEVER, 40, 49, NEVER);
    check("loss_run_still", act, pk(0, 1, 1, 0, 0));
    advance(42, 10, NEVER, 40, 49, NEVER);
    check("loss_pulse", act, pk(1, 0, 0, 0, 0));
    advance(59, 10, NEVER, 40, 49, NEVER);
    check("loss_before_rerun", act, pk(0, 0, 0, 0, 0));
    advance(60, 10, NEVER, 40, 49, NEVER);
    check("loss_rerun", act, pk(0, 1, 1, 0, 0));

    // Two-cycle lock glitch during STABILIZE.
    do_reset();
    advance(15, 10, NEVER, 14, 15, NEVER);
    check("glitch_stab", act, pk(0, 0, 0, 0, 0));
    advance(16, 10, NEVER, 14, 15, NEVER);
    check("glitch_pulse", act, pk(1, 0, 0, 0, 0));
    advance(20, 10, NEVER, 14, 15, NEVER);
    check("glitch_wait", act, pk(0, 0, 0, 0, 0));
    advance(28, 10, NEVER, 14, 15, NEVER);
    check("glitch_no_early_run", act, pk(0, 0, 0, 0, 0));
    advance(29, 10, NEVER, 14, 15, NEVER);
    check("glitch_run", act, pk(0, 1, 1, 0, 0));

    // Asynchronous reset in the middle of STABILIZE.
    do_reset();
    advance(37, 32, NEVER, NEVER, NEVER, NEVER);
    check("async_pre", act, pk(0, 0, 0, 0, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", act, pk(1, 0, 0, 0, 0));

    // Restart on the same edge as lock loss in RUN.
    do_reset();
    advance(51, 32, 50, NEVER, NEVER, NEVER);
    check("rs_loss_pre", act, pk(0, 1, 1, 0, 1));
    advance(52, 32, 50, NEVER, NEVER, 52);
    check("rs_loss_edge", act, pk(1, 0, 0, 0, 0));
    advance(56, 32, 50, NEVER, NEVER, NEVER);
    check("rs_loss_pulse", act, pk(1, 0, 0, 0, 0));
    advance(57, 32, 50, NEVER, NEVER, NEVER);
    check("rs_loss_wait", act, pk(0, 0, 0, 0, 0));

    // Randomized lock/restart activity against the reference model.
    do_reset();
    model_reset();
    lk = 1'b0;
    rate = 4;
    start_fail = n_fail;
    for (int c = 0; c < 3000 && (n_fail - start_fail) < 10; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 4;
          1:       rate = 40;
          default: rate = 150;
        endcase
      end
      if ($urandom_range(0, rate - 1) == 0) lk = !lk;
      rs = ($urandom_range(0, 299) == 0);
      i_locked  = lk;
      i_restart = rs;
      step();
      model_edge(lk, rs);
      check("random", act, model_exp());
    end
    i_restart = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
